led_spin_sequencer: RTL and testbench

LED_SPIN_SEQUENCER -- requirements
Module: led_spin_sequencer

---
 rtl/led_spin_if.sv | 31 +++
 rtl/led_spin_sequencer.sv | 172 +++++++++++++++++
 tb/tb_led_spin_sequencer.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/led_spin_if.sv
// Button inputs and LED outputs of the LED spin sequencer.
// The board or bench side is the master and the sequencer is the slave.
interface led_spin_if;
  logic btn_mode;
  logic btn_speed;
  logic D1;
  logic D2;
  logic D3;
  logic D4;
  logic D5;

  modport master (
    output btn_mode,
    output btn_speed,
    input  D1,
    input  D2,
    input  D3,
    input  D4,
    input  D5
  );

  modport slave (
    input  btn_mode,
    input  btn_speed,
    output D1,
    output D2,
    output D3,
    output D4,
    output D5
  );
endinterface

// File: rtl/led_spin_sequencer.sv
// Four-LED spin pattern generator with debounced mode/speed buttons and an optional
// D5 heartbeat, which is built only when LED_SPIN_HEARTBEAT_EN is defined.
module led_spin_sequencer #(
  parameter int unsigned STEP_DIV        = 12000000,
  parameter int unsigned DEBOUNCE_CYCLES = 120000,
  parameter int unsigned HB_DIV          = 12500000
) (
  input logic       clk,
  input logic       rst,
  led_spin_if.slave io
);

  localparam int unsigned DivW = $clog2(STEP_DIV);
  localparam int unsigned DbW  = $clog2(DEBOUNCE_CYCLES);
  localparam logic DirLeft  = 1'b0;
  localparam logic DirRight = 1'b1;

  typedef enum logic [2:0] {StCw, StCcw, StBounce, StBlink, StOff} mode_e;

  // Bit 0 is the mode button and bit 1 is the speed button.
  logic [1:0]           btn_raw;
  logic [1:0]           sync1_q, sync2_q;
  logic [1:0]           db_q, db_d;
  logic [1:0]           ev_q, ev_d;
  logic [1:0][DbW-1:0]  db_cnt_q, db_cnt_d;

  mode_e                mode_q, mode_d;
  logic [3:0]           rot_q, rot_d;
  logic                 dir_q, dir_d;
  logic [1:0]           speed_q, speed_d;
  logic [DivW-1:0]      div_q, div_d;
  logic [31:0]          step_lim;
  logic                 tick;
  logic                 mode_ev, speed_ev;

  assign btn_raw = {io.btn_speed, io.btn_mode};

  // Debouncer: accept the synced level only after it differs for DEBOUNCE_CYCLES cycles.
  always_comb begin
    db_d     = db_q;
    ev_d     = '0;
    db_cnt_d = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != db_q[i]) begin
        if (db_cnt_q[i] == DbW'(DEBOUNCE_CYCLES - 1)) begin
          db_d[i] = sync2_q[i];
          ev_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
        end
      end
    end
  end

  assign mode_ev  = ev_q[0];
  assign speed_ev = ev_q[1];

  assign step_lim = (STEP_DIV >> speed_q) - 32'd1;
  assign tick     = ({{(32 - DivW){1'b0}}, div_q} == step_lim);

  always_comb begin
    mode_d  = mode_q;
    rot_d   = rot_q;
    dir_d   = dir_q;
    speed_d = speed_q;
    div_d   = tick ? '0 : div_q + DivW'(1);

    if (tick) begin
      unique case (mode_q)
        StCw:  rot_d = {rot_q[2:0], rot_q[3]};
        StCcw: rot_d = {rot_q[0], rot_q[3:1]};
        StBounce: begin
          if (dir_q == DirLeft) begin
            if (rot_q[3]) begin
              rot_d = 4'b0100;
              dir_d = DirRight;
            end else begin
              rot_d = {rot_q[2:0], 1'b0};
            end
          end else begin
            if (rot_q[0]) begin
              rot_d = 4'b0010;
              dir_d = DirLeft;
            end else begin
              rot_d = {1'b0, rot_q[3:1]};
            end
          end
        end
        StBlink: rot_d = ~rot_q;
        StOff:   rot_d = 4'b0000;
        default: rot_d = rot_q;
      endcase
    end

    if (speed_ev) begin
      speed_d = speed_q + 2'd1;
      div_d   = '0;
    end

    // A mode event overrides any step computed above for this cycle.
    if (mode_ev) begin
      unique case (mode_q)
        StCw:     mode_d = StCcw;
        StCcw:    mode_d = StBounce;
        StBounce: mode_d = StBlink;
        StBlink:  mode_d = StOff;
        StOff:    mode_d = StCw;
        default:  mode_d = StCw;
      endcase
      rot_d = (mode_d == StBlink || mode_d == StOff) ? 4'b0000 : 4'b0001;
      dir_d = DirLeft;
      div_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      db_q     <= '0;
      ev_q     <= '0;
      db_cnt_q <= '0;
      mode_q   <= StCw;
      rot_q    <= 4'b0001;
      dir_q    <= DirLeft;
      speed_q  <= '0;
      div_q    <= '0;
    end else begin
      sync1_q  <= btn_raw;
      sync2_q  <= sync1_q;
      db_q     <= db_d;
      ev_q     <= ev_d;
      db_cnt_q <= db_cnt_d;
      mode_q   <= mode_d;
      rot_q    <= rot_d;
      dir_q    <= dir_d;
      speed_q  <= speed_d;
      div_q    <= div_d;
    end
  end

  assign io.D1 = rot_q[0];
  assign io.D2 = rot_q[1];
  assign io.D3 = rot_q[2];
  assign io.D4 = rot_q[3];

`ifdef LED_SPIN_HEARTBEAT_EN
  localparam int unsigned HbW = $clog2(HB_DIV);

  logic [HbW-1:0] hb_cnt_q;
  logic           hb_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hb_cnt_q <= '0;
      hb_q     <= 1'b0;
    end else if (hb_cnt_q == HbW'(HB_DIV - 1)) begin
      hb_cnt_q <= '0;
      hb_q     <= ~hb_q;
    end else begin
      hb_cnt_q <= hb_cnt_q + HbW'(1);
    end
  end

  assign io.D5 = hb_q;
`else
  logic unused_hb_div;
  assign unused_hb_div = ^HB_DIV;
  assign io.D5 = 1'b0;
`endif

endmodule

// File: tb/tb_led_spin_sequencer.sv
// Directed bench for led_spin_sequencer with STEP_DIV=8, DEBOUNCE_CYCLES=4, HB_DIV=5.
// D5 expectations follow LED_SPIN_HEARTBEAT_EN as compiled.
module tb_led_spin_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   since_rst = 0;
  logic [3:0] leds;
  logic [3:0] bounce_seq [9];

  led_spin_if bus ();

  led_spin_sequencer #(
    .STEP_DIV       (8),
    .DEBOUNCE_CYCLES(4),
    .HB_DIV         (5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io (bus)
  );

  always #5 clk = ~clk;

  assign leds = {bus.D4, bus.D3, bus.D2, bus.D1};

  function automatic logic [3:0] rol(input logic [3:0] v, input int n);
    logic [3:0] r = v;
    for (int i = 0; i < n; i++) r = {r[2:0], r[3]};
    return r;
  endfunction

  function automatic logic in_win(input int k, input int s);
    return (k > s) && (k <= s + 10);
  endfunction

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %b want %b at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %b want %b at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // One clock edge, then check D5 against the cycle count since the last reset edge.
  task automatic cyc();
    logic d5_exp;
    @(posedge clk);
    if (rst) since_rst = 0;
    else since_rst++;
    #1;
`ifdef LED_SPIN_HEARTBEAT_EN
    d5_exp = ((since_rst / 5) % 2) == 1;
`else
    d5_exp = 1'b0;
`endif
    chk1("d5", bus.D5, d5_exp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.btn_mode  = 1'b0;
    bus.btn_speed = 1'b0;
    cyc();
    cyc();
    chk4("reset_rot", leds, 4'b0001);
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] exp;
    bounce_seq[0] = 4'b0001; bounce_seq[1] = 4'b0010; bounce_seq[2] = 4'b0100;
    bounce_seq[3] = 4'b1000; bounce_seq[4] = 4'b0100; bounce_seq[5] = 4'b0010;
    bounce_seq[6] = 4'b0001; bounce_seq[7] = 4'b0010; bounce_seq[8] = 4'b0100;

    // CW free run: each pattern held exactly 8 cycles.
    do_reset();
    for (int k = 1; k <= 40; k++) begin
      cyc();
      chk4("cw_run", leds, rol(4'b0001, k / 8));
    end

    // Mode press of 10 cycles: CCW entered at edge 7, then steps at edges 15 and 23.
    do_reset();
    for (int k = 1; k <= 24; k++) begin
      bus.btn_mode = (k <= 10);
      cyc();
      exp = (k < 15) ? 4'b0001 : (k < 23) ? 4'b1000 : 4'b0100;
      chk4("ccw", leds, exp);
    end

    // 2-cycle glitch is rejected; CW keeps running.
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      bus.btn_mode = (k <= 2);
      cyc();
      chk4("glitch", leds, rol(4'b0001, k / 8));
    end

    // Three presses reach BLINK at edge 47.
    do_reset();
    for (int k = 1; k <= 70; k++) begin
      bus.btn_mode = in_win(k, 0) || in_win(k, 20) || in_win(k, 40);
      cyc();
      if (k >= 47) begin
        exp = (k < 55) ? 4'b0000 : (k < 63) ? 4'b1111 : 4'b0000;
        chk4("blink", leds, exp);
      end
    end

    // Speed presses take effect at edges 7, 28, 49 and 69.
    do_reset();
    for (int k = 1; k <= 86; k++) begin
      bus.btn_speed = in_win(k, 0) || in_win(k, 21) || in_win(k, 42) || in_win(k, 62);
      cyc();
      if (k >= 7 && k <= 27) chk4("speed1", leds, rol(4'b0001, (k - 7) / 4));
      if (k >= 29 && k <= 40) chk4("speed2", leds, rol(4'b0010, (k - 28) / 2));
      if (k >= 50 && k <= 60) chk4("speed3", leds, rol(4'b1000, k - 49));
      if (k >= 70) begin
        exp = (k < 77) ? 4'b1000 : (k < 85) ? 4'b0001 : 4'b0010;
        chk4("speed0", leds, exp);
      end
    end

    // Two presses reach BOUNCE at edge 27, then reset mid-sequence.
    do_reset();
    for (int k = 1; k <= 92; k++) begin
      bus.btn_mode = in_win(k, 0) || in_win(k, 20);
      cyc();
      if (k >= 28) chk4("bounce", leds, bounce_seq[(k - 27) / 8]);
    end
    rst = 1'b1;
    cyc();
    chk4("mid_reset", leds, 4'b0001);
    rst = 1'b0;
    for (int k = 1; k <= 33; k++) begin
      cyc();
      chk4("post_reset_cw", leds, rol(4'b0001, k / 8));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
